ic_tx: RTL

- Per-MVU transmit endpoint for the MVU-to-MVU crossbar interconnect.
- Accepts messages from the local MVU through a valid/ready handshake and buffers them in a small FIFO.
- Drives one slot of the crossbar's sendValid/sendAddr/sendMsg buses. The crossbar has no backpressure, so each message is presented for a fixed HOLD cycles and then retired.
- One instance per crossbar slot; n instances together feed the interconnect.

---
 rtl/ic_pkg.sv | 16 +
 rtl/ic_tx_if.sv | 17 +
 rtl/ic_fifo.sv | 48 ++++
 rtl/ic_tx.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared constants, state encoding and address-width helper for the crossbar interconnect.
package ic_pkg;

  localparam int IC_N = 32;
  localparam int IC_W = 96;

  typedef enum logic {
    IC_TX_IDLE = 1'b0,
    IC_TX_SEND = 1'b1
  } ic_tx_state_e;

  function automatic int ic_addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ic_tx_if.sv
// Local-MVU-to-transmit-endpoint message handshake (valid/ready with address tag and payload).
interface ic_tx_if
  import ic_pkg::*;
#(
  parameter int A = ic_addr_w(IC_N),
  parameter int W = IC_W
) ();

  logic         inValid;
  logic         inReady;
  logic [A-1:0] inAddr;
  logic [W-1:0] inMsg;

  modport master (output inValid, output inAddr, output inMsg, input inReady);
  modport slave  (input inValid, input inAddr, input inMsg, output inReady);

endinterface

// File: rtl/ic_fifo.sv
// Power-of-two circular FIFO with registered occupancy count; async active-low reset.
module ic_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/ic_tx.sv
// ic_tx: per-slot crossbar transmit endpoint; buffers messages and presents each for HOLD cycles.
// Define IC_TX_STATS_EN to add the sentCount and dropOnReset outputs.
module ic_tx
  import ic_pkg::*;
#(
  parameter int  n     = IC_N,
  parameter int  w     = IC_W,
  parameter int  DEPTH = 4,
  parameter int  HOLD  = 1,
  localparam int a     = ic_addr_w(n),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  ic_tx_if.slave        in_if,
  output logic          sendValid,
  output logic [a-1:0]  sendAddr,
  output logic [w-1:0]  sendMsg,
  output logic [LW-1:0] level
`ifdef IC_TX_STATS_EN
  ,
  output logic [31:0]   sentCount,
  output logic          dropOnReset
`endif
);

  localparam int            HW          = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD - 1);

  ic_tx_state_e   state_q, state_d;
  logic           vld_q, vld_d;
  logic [a-1:0]   addr_q, addr_d;
  logic [w-1:0]   msg_q, msg_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           push, pop;
  logic           fifo_full, fifo_empty;
  logic [a+w-1:0] fifo_dout;

  assign in_if.inReady = !fifo_full;
  assign push          = in_if.inValid && !fifo_full;

  ic_fifo #(
    .WIDTH (a + w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({in_if.inAddr, in_if.inMsg}),
    .dout  (fifo_dout),
    .count (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // pop doubles as the load strobe for the output register in both states
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    addr_d  = addr_q;
    msg_d   = msg_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    unique case (state_q)
      IC_TX_IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      IC_TX_SEND: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end else begin
          vld_d   = 1'b0;
          state_d = IC_TX_IDLE;
        end
      end
      default: state_d = IC_TX_IDLE;
    endcase
    if (pop) begin
      state_d          = IC_TX_SEND;
      vld_d            = 1'b1;
      {addr_d, msg_d}  = fifo_dout;
      hold_d           = HOLD_RELOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IC_TX_IDLE;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      msg_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      msg_q   <= msg_d;
      hold_q  <= hold_d;
    end
  end

  assign sendValid = vld_q;
  assign sendAddr  = addr_q;
  assign sendMsg   = msg_q;

`ifdef IC_TX_STATS_EN
  logic [31:0] sent_q;
  logic        started_q, drop_q, vld_at_rst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent_q    <= '0;
      started_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      if (pop) sent_q <= sent_q + 32'd1;
      started_q <= 1'b1;
      drop_q    <= !started_q && vld_at_rst_q;
    end
  end

  // Deliberately not reset: freezes while rst is low so it remembers a send in flight.
  always_ff @(posedge clk) begin
    if (rst) vld_at_rst_q <= vld_d;
  end

  assign sentCount   = sent_q;
  assign dropOnReset = drop_q;
`endif

endmodule
